// File: rtl/multi_phase_light_ctrl_pkg.sv
// Shared definitions for the multi-direction traffic light controller:
// state encoding and the round-robin direction step.
package multi_phase_light_ctrl_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ALLRED = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    WALK   = 3'd3,
    FLASH  = 3'd4
  } state_e;

  function automatic int next_dir(input int d, input int n_dir);
    return (d == n_dir - 1) ? 0 : d + 1;
  endfunction

endpackage

// File: rtl/multi_phase_light_ctrl_tick_prescaler.sv
// Divides the system clock into a one-cycle time-unit tick every CLK_DIV clocks.
module tick_prescaler #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] count_q, count_d;

  assign tick = (count_q == CW'(CLK_DIV - 1));

  always_comb begin
    count_d = tick ? '0 : count_q + 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule

// File: rtl/multi_phase_light_ctrl.sv
// Round-robin N_DIR-direction traffic light with pedestrian walk phase and
// night flashing mode; all phase durations are in prescaled ticks.
module multi_phase_light_ctrl
  import multi_phase_light_ctrl_pkg::*;
#(
  parameter int N_DIR    = 2,
  parameter int CLK_DIV  = 1000,
  parameter int T_GREEN  = 10,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 5,
  parameter int T_FLASH  = 1,
  parameter int TW       = 8,
  localparam int DW      = $clog2(N_DIR)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             N,
  input  logic             ped_req,
  output logic [N_DIR-1:0] green,
  output logic [N_DIR-1:0] yellow,
  output logic [N_DIR-1:0] red,
  output logic             walk,
  output logic [DW-1:0]    dir
);

  logic          tick;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, t_last;
  logic [DW-1:0] dir_q, dir_d;
  logic          flash_q, flash_d;
  logic          ped_pend_q, ped_pend_d;
  logic          expire;
  logic [N_DIR-1:0] dir_onehot;

  tick_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_comb begin
    case (state_q)
      ALLRED:  t_last = TW'(T_ALLRED - 1);
      GREEN:   t_last = TW'(T_GREEN - 1);
      YELLOW:  t_last = TW'(T_YELLOW - 1);
      WALK:    t_last = TW'(T_WALK - 1);
      FLASH:   t_last = TW'(T_FLASH - 1);
      default: t_last = '0;
    endcase
  end

  assign expire = tick && (timer_q == t_last);

  // NOTE: every next-state variable gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    flash_d    = flash_q;
    ped_pend_d = ped_pend_q | (ped_req && state_q != WALK);

    if (tick) begin
      case (state_q)
        ALLRED: if (expire) begin
          if (N)               state_d = FLASH;
          else if (ped_pend_q) state_d = WALK;
          else begin
            state_d = GREEN;
            dir_d   = DW'(next_dir(int'(dir_q), N_DIR));
          end
        end
        GREEN:  if (expire || N) state_d = YELLOW;
        YELLOW: if (expire)      state_d = ALLRED;
        WALK:   if (expire) begin
          state_d = GREEN;
          dir_d   = DW'(next_dir(int'(dir_q), N_DIR));
        end
        FLASH: begin
          // Leaving night mode restarts the rotation so direction 0 goes first.
          if (!N) begin
            state_d = ALLRED;
            dir_d   = DW'(N_DIR - 1);
          end else if (expire) begin
            flash_d = ~flash_q;
          end
        end
        default: state_d = ALLRED;
      endcase
    end

    if (state_d != state_q) begin
      timer_d = '0;
      if (state_d == WALK || state_d == FLASH) ped_pend_d = 1'b0;
    end else if (tick) begin
      timer_d = expire ? '0 : timer_q + 1'b1;
    end else begin
      timer_d = timer_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALLRED;
      timer_q    <= '0;
      dir_q      <= DW'(N_DIR - 1);
      flash_q    <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      dir_q      <= dir_d;
      flash_q    <= flash_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  assign dir_onehot = N_DIR'(1) << dir_q;
  assign dir        = dir_q;

  always_comb begin
    green  = '0;
    yellow = '0;
    red    = '0;
    walk   = 1'b0;
    case (state_q)
      GREEN: begin
        green = dir_onehot;
        red   = ~dir_onehot;
      end
      YELLOW: begin
        yellow = dir_onehot;
        red    = ~dir_onehot;
      end
      WALK: begin
        red  = '1;
        walk = 1'b1;
      end
      FLASH:   yellow = {N_DIR{flash_q}};
      default: red = '1;
    endcase
  end

endmodule

// File: tb/tb_multi_phase_light_ctrl.sv
// Directed scoreboard bench: a 2-direction and a 3-direction instance with
// small timing parameters, lamp state checked every clock.
module tb_multi_phase_light_ctrl;

  logic       clk, rst, rst3, night, night3, ped, ped3;
  logic [1:0] g2, y2, r2;
  logic       w2;
  logic [0:0] d2;
  logic [2:0] g3, y3, r3;
  logic       w3;
  logic [1:0] d3;

  typedef struct {
    bit         sel;
    logic [2:0] g, y, r;
    logic       w;
    logic [1:0] d;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  multi_phase_light_ctrl #(
    .N_DIR(2), .CLK_DIV(4), .T_GREEN(3), .T_YELLOW(2), .T_ALLRED(1),
    .T_WALK(2), .T_FLASH(1), .TW(8)
  ) dut2 (
    .clk(clk), .rst(rst), .N(night), .ped_req(ped),
    .green(g2), .yellow(y2), .red(r2), .walk(w2), .dir(d2)
  );

  multi_phase_light_ctrl #(
    .N_DIR(3), .CLK_DIV(4), .T_GREEN(3), .T_YELLOW(2), .T_ALLRED(1),
    .T_WALK(2), .T_FLASH(1), .TW(8)
  ) dut3 (
    .clk(clk), .rst(rst3), .N(night3), .ped_req(ped3),
    .green(g3), .yellow(y3), .red(r3), .walk(w3), .dir(d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare();
    exp_t        e;
    logic [11:0] obs, want;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: observed empty queue, required an entry");
      return;
    end
    e    = sb.pop_front();
    obs  = e.sel ? {g3, y3, r3, w3, d3}
                 : {1'b0, g2, 1'b0, y2, 1'b0, r2, w2, 1'b0, d2};
    want = {e.g, e.y, e.r, e.w, e.d};
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed g/y/r/w/dir=%b required %b", e.tag, obs, want);
    end
  endtask

  task automatic expect_now(input bit sel, input logic [2:0] g, y, r,
                            input logic w, input logic [1:0] d, input string tag);
    sb.push_back('{sel, g, y, r, w, d, tag});
    compare();
  endtask

  // Expect the next n post-edge lamp states to equal the given pattern.
  task automatic hold(input int n, input bit sel, input logic [2:0] g, y, r,
                      input logic w, input logic [1:0] d, input string tag);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{sel, g, y, r, w, d, $sformatf("%s[%0d]", tag, i)});
      @(posedge clk);
      @(negedge clk);
      compare();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of stimulus, required finish before 200000");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst = 1'b1; rst3 = 1'b1; night = 1'b0; night3 = 1'b0; ped = 1'b0; ped3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Scenario 1: plain rotation after reset.
    rst = 1'b0;
    expect_now(0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd1, "s1_reset");
    hold(3,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd1, "s1_allred_init");
    hold(12, 0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s1_green0");
    hold(8,  0, 3'b000, 3'b001, 3'b010, 1'b0, 2'd0, "s1_yellow0");
    hold(4,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd0, "s1_allred0");
    hold(12, 0, 3'b010, 3'b000, 3'b001, 1'b0, 2'd1, "s1_green1");
    hold(8,  0, 3'b000, 3'b010, 3'b001, 1'b0, 2'd1, "s1_yellow1");
    hold(4,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd1, "s1_allred1");

    // Scenario 2: pedestrian request in green dir0, repeat request during walk.
    hold(2,  0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s2_green0");
    ped = 1'b1;
    hold(1,  0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s2_green0_req");
    ped = 1'b0;
    hold(9,  0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s2_green0_tail");
    hold(8,  0, 3'b000, 3'b001, 3'b010, 1'b0, 2'd0, "s2_yellow0");
    hold(4,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd0, "s2_allred0");
    hold(3,  0, 3'b000, 3'b000, 3'b011, 1'b1, 2'd0, "s2_walk");
    ped = 1'b1;
    hold(1,  0, 3'b000, 3'b000, 3'b011, 1'b1, 2'd0, "s2_walk_req");
    ped = 1'b0;
    hold(4,  0, 3'b000, 3'b000, 3'b011, 1'b1, 2'd0, "s2_walk_tail");
    hold(12, 0, 3'b010, 3'b000, 3'b001, 1'b0, 2'd1, "s2_green1");
    hold(8,  0, 3'b000, 3'b010, 3'b001, 1'b0, 2'd1, "s2_yellow1");
    hold(4,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd1, "s2_allred1");

    // Scenario 3: night request cuts green dir0, then flashing.
    hold(5,  0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s3_green0");
    night = 1'b1;
    hold(3,  0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s3_green0_cut");
    hold(8,  0, 3'b000, 3'b001, 3'b010, 1'b0, 2'd0, "s3_yellow0");
    hold(4,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd0, "s3_allred0");
    hold(4,  0, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0, "s3_flash_off");
    hold(4,  0, 3'b000, 3'b011, 3'b000, 1'b0, 2'd0, "s3_flash_on");
    hold(4,  0, 3'b000, 3'b000, 3'b000, 1'b0, 2'd0, "s3_flash_off2");
    hold(2,  0, 3'b000, 3'b011, 3'b000, 1'b0, 2'd0, "s3_flash_on2");

    // Scenario 4: night drops mid-flash; rotation restarts at dir0.
    night = 1'b0;
    hold(2,  0, 3'b000, 3'b011, 3'b000, 1'b0, 2'd0, "s4_flash_tail");
    hold(4,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd1, "s4_allred");
    hold(3,  0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s4_green0");
    ped = 1'b1;
    hold(1,  0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s4_green0_req");
    ped = 1'b0;
    hold(8,  0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s4_green0_tail");

    // Scenario 5: reset mid-yellow drops the pending walk request.
    hold(4,  0, 3'b000, 3'b001, 3'b010, 1'b0, 2'd0, "s5_yellow0");
    rst = 1'b1;
    hold(1,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd1, "s5_reset");
    rst = 1'b0;
    hold(3,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd1, "s5_allred");
    hold(12, 0, 3'b001, 3'b000, 3'b010, 1'b0, 2'd0, "s5_green0");
    hold(8,  0, 3'b000, 3'b001, 3'b010, 1'b0, 2'd0, "s5_yellow0_b");
    hold(4,  0, 3'b000, 3'b000, 3'b011, 1'b0, 2'd0, "s5_allred0");
    hold(4,  0, 3'b010, 3'b000, 3'b001, 1'b0, 2'd1, "s5_no_walk");

    // Scenario 6: three directions rotate 001, 010, 100, 001.
    rst3 = 1'b0;
    expect_now(1, 3'b000, 3'b000, 3'b111, 1'b0, 2'd2, "s6_reset");
    hold(3, 1, 3'b000, 3'b000, 3'b111, 1'b0, 2'd2, "s6_allred_init");
    for (int k = 0; k < 3; k++) begin
      logic [2:0] oh;
      oh = 3'b001 << k;
      hold(12, 1, oh,     3'b000, ~oh,    1'b0, 2'(k), $sformatf("s6_green%0d", k));
      hold(8,  1, 3'b000, oh,     ~oh,    1'b0, 2'(k), $sformatf("s6_yellow%0d", k));
      hold(4,  1, 3'b000, 3'b000, 3'b111, 1'b0, 2'(k), $sformatf("s6_allred%0d", k));
    end
    hold(12, 1, 3'b001, 3'b000, 3'b110, 1'b0, 2'd0, "s6_green_wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
